// File: rtl/frame_sequencer.sv
// Frame-level controller: init, per-pass setup, render-state handshake, completion, vsync.
// Optional frame timing counters are enabled by defining FRAME_SEQ_PERF_EN.
module frame_sequencer #(
  parameter int NUM_CORES   = 4,
  parameter int PIX_W       = 32,
  parameter int PIXEL_COUNT = 76800,
  parameter int SAMPLES     = 1,
  parameter int RS_TIMEOUT  = 4095,
  parameter int FRAME_CNT_W = 16
) (
  input  logic                       clk,
  input  logic                       resetn,
  input  logic                       vsync,
  input  logic                       free_run,
  input  logic                       bvh_init_done,
  input  logic                       rs_valid,
  input  logic [NUM_CORES*PIX_W-1:0] core_pixel_count,
  output logic                       flip,
  output logic                       rs_strobe,
  output logic                       tg_strobe,
  output logic                       tg_reset,
  output logic                       reset_pixel_counter,
  output logic [7:0]                 sample_index,
  output logic [FRAME_CNT_W-1:0]     frame_count,
  output logic [15:0]                frame_kcycles,
  output logic                       rs_timeout_err,
  output logic                       busy
);

  localparam int SUM_W  = PIX_W + $clog2(NUM_CORES);
  localparam int WAIT_W = $clog2(RS_TIMEOUT + 1);

  localparam logic [SUM_W-1:0]  PIX_TGT     = SUM_W'(PIXEL_COUNT);
  localparam logic [7:0]        LAST_SAMPLE = 8'(SAMPLES - 1);
  localparam logic [WAIT_W-1:0] WAIT_LAST   = WAIT_W'(RS_TIMEOUT - 1);

  typedef enum logic [2:0] {
    S_INIT,
    S_FRAME_SETUP,
    S_RS_SETUP,
    S_RENDER,
    S_WAIT_VSYNC
  } state_e;

  state_e state_q, state_d;

  logic [SUM_W-1:0]       sum_q, sum_d;
  logic [1:0]             render_cnt_q, render_cnt_d;
  logic [WAIT_W-1:0]      wait_q, wait_d;
  logic [7:0]             sample_q, sample_d;
  logic [FRAME_CNT_W-1:0] frame_cnt_q, frame_cnt_d;

  logic flip_q, flip_d;
  logic setup_pulse_q, setup_pulse_d;
  logic tg_strobe_q, tg_strobe_d;
  logic busy_q, busy_d;
  logic err_q, err_d;

  logic complete;
  logic last_pass;
  logic toggle;

  // Stage 1: full-width sum of all core counters
  always_comb begin
    sum_d = '0;
    for (int i = 0; i < NUM_CORES; i++) begin
      sum_d = sum_d + SUM_W'(core_pixel_count[i*PIX_W +: PIX_W]);
    end
  end

  // Stage 2: compare, masked for the first two render cycles
  assign complete  = (render_cnt_q == 2'd2) && (sum_q >= PIX_TGT);
  assign last_pass = (sample_q == LAST_SAMPLE);

  always_comb begin
    state_d     = state_q;
    sample_d    = sample_q;
    frame_cnt_d = frame_cnt_q;
    wait_d      = wait_q;
    err_d       = err_q;
    toggle      = 1'b0;

    unique case (state_q)
      S_INIT: begin
        if (bvh_init_done) begin
          state_d = S_FRAME_SETUP;
          toggle  = (sample_q == 8'd0);
        end
      end
      S_FRAME_SETUP: begin
        wait_d  = '0;
        state_d = S_RS_SETUP;
      end
      S_RS_SETUP: begin
        if (rs_valid) begin
          state_d = S_RENDER;
        end else if (wait_q == WAIT_LAST) begin
          err_d   = 1'b1;
          state_d = S_FRAME_SETUP;
        end else begin
          wait_d = wait_q + WAIT_W'(1);
        end
      end
      S_RENDER: begin
        if (complete) begin
          if (!last_pass) begin
            sample_d = sample_q + 8'd1;
            state_d  = S_FRAME_SETUP;
          end else begin
            sample_d    = 8'd0;
            frame_cnt_d = frame_cnt_q + FRAME_CNT_W'(1);
            state_d     = S_WAIT_VSYNC;
          end
        end
      end
      S_WAIT_VSYNC: begin
        if (!vsync || free_run) begin
          state_d = S_FRAME_SETUP;
          toggle  = (sample_q == 8'd0);
        end
      end
      default: state_d = S_INIT;
    endcase

    render_cnt_d = '0;
    if (state_q == S_RENDER) begin
      render_cnt_d = (render_cnt_q == 2'd2) ? render_cnt_q
                                            : render_cnt_q + 2'd1;
    end

    flip_d        = flip_q ^ toggle;
    setup_pulse_d = (state_d == S_FRAME_SETUP);
    tg_strobe_d   = (state_d == S_RENDER);
    busy_d        = (state_d != S_INIT) && (state_d != S_WAIT_VSYNC);
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      state_q       <= S_INIT;
      sum_q         <= '0;
      render_cnt_q  <= '0;
      wait_q        <= '0;
      sample_q      <= '0;
      frame_cnt_q   <= '0;
      flip_q        <= 1'b0;
      setup_pulse_q <= 1'b0;
      tg_strobe_q   <= 1'b0;
      busy_q        <= 1'b0;
      err_q         <= 1'b0;
    end else begin
      state_q       <= state_d;
      sum_q         <= sum_d;
      render_cnt_q  <= render_cnt_d;
      wait_q        <= wait_d;
      sample_q      <= sample_d;
      frame_cnt_q   <= frame_cnt_d;
      flip_q        <= flip_d;
      setup_pulse_q <= setup_pulse_d;
      tg_strobe_q   <= tg_strobe_d;
      busy_q        <= busy_d;
      err_q         <= err_d;
    end
  end

`ifdef FRAME_SEQ_PERF_EN
  logic [9:0]  presc_q, presc_d;
  logic [15:0] kc_q, kc_d;
  logic [15:0] fk_q, fk_d;
  logic        frame_done;

  assign frame_done = (state_q == S_RENDER) && complete && last_pass;

  // Kilo-cycle count restarts with each displayed frame
  always_comb begin
    presc_d = presc_q + 10'd1;
    kc_d    = kc_q;
    if (presc_q == 10'h3ff && kc_q != 16'hffff) begin
      kc_d = kc_q + 16'd1;
    end
    if (toggle) begin
      presc_d = '0;
      kc_d    = '0;
    end
    fk_d = frame_done ? kc_d : fk_q;
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      presc_q <= '0;
      kc_q    <= '0;
      fk_q    <= '0;
    end else begin
      presc_q <= presc_d;
      kc_q    <= kc_d;
      fk_q    <= fk_d;
    end
  end

  assign frame_kcycles = fk_q;
`else
  assign frame_kcycles = 16'd0;
`endif

  assign flip                = flip_q;
  assign rs_strobe           = setup_pulse_q;
  assign tg_reset            = setup_pulse_q;
  assign reset_pixel_counter = setup_pulse_q;
  assign tg_strobe           = tg_strobe_q;
  assign sample_index        = sample_q;
  assign frame_count         = frame_cnt_q;
  assign rs_timeout_err      = err_q;
  assign busy                = busy_q;

endmodule

// File: tb/tb_frame_sequencer.sv
// Directed bench for frame_sequencer: single-pass instance and 3-sample free-run instance.
// Frame timing checks follow FRAME_SEQ_PERF_EN.
module tb_frame_sequencer;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic         resetn;
  logic         vsync;
  logic         free_run;
  logic         bvh;
  logic         rs_valid;
  logic [127:0] cores;

  logic        flip, rs_strobe, tg_strobe, tg_reset, rpc, err, busy;
  logic [7:0]  sample_index;
  logic [15:0] frame_count;
  logic [15:0] frame_kcycles;

  logic         b_init;
  logic         b_one;
  logic         b_vsync;
  logic [127:0] b_cores;

  logic        b_flip, b_rs_strobe, b_tg_strobe, b_tg_reset, b_rpc, b_err, b_busy;
  logic [7:0]  b_sample;
  logic [15:0] b_frame_count;
  logic [15:0] b_kcycles;

  int n_assert = 0;
  int n_fail   = 0;

  frame_sequencer #(
    .NUM_CORES(4), .PIX_W(32), .PIXEL_COUNT(100),
    .SAMPLES(1), .RS_TIMEOUT(15), .FRAME_CNT_W(16)
  ) u_dut (
    .clk(clk), .resetn(resetn), .vsync(vsync), .free_run(free_run),
    .bvh_init_done(bvh), .rs_valid(rs_valid), .core_pixel_count(cores),
    .flip(flip), .rs_strobe(rs_strobe), .tg_strobe(tg_strobe),
    .tg_reset(tg_reset), .reset_pixel_counter(rpc),
    .sample_index(sample_index), .frame_count(frame_count),
    .frame_kcycles(frame_kcycles), .rs_timeout_err(err), .busy(busy)
  );

  frame_sequencer #(
    .NUM_CORES(4), .PIX_W(32), .PIXEL_COUNT(100),
    .SAMPLES(3), .RS_TIMEOUT(15), .FRAME_CNT_W(16)
  ) u_dut_acc (
    .clk(clk), .resetn(resetn), .vsync(b_vsync), .free_run(b_one),
    .bvh_init_done(b_init), .rs_valid(b_one), .core_pixel_count(b_cores),
    .flip(b_flip), .rs_strobe(b_rs_strobe), .tg_strobe(b_tg_strobe),
    .tg_reset(b_tg_reset), .reset_pixel_counter(b_rpc),
    .sample_index(b_sample), .frame_count(b_frame_count),
    .frame_kcycles(b_kcycles), .rs_timeout_err(b_err), .busy(b_busy)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic set_cores(input logic [31:0] v);
    cores = {4{v}};
  endtask

  initial begin
    logic [31:0] exp_kc;
`ifdef FRAME_SEQ_PERF_EN
    exp_kc = 32'd2;
`else
    exp_kc = 32'd0;
`endif
    resetn   = 1'b0;
    vsync    = 1'b1;
    free_run = 1'b0;
    bvh      = 1'b0;
    rs_valid = 1'b0;
    cores    = '0;
    b_init   = 1'b0;
    b_one    = 1'b1;
    b_vsync  = 1'b1;
    b_cores  = {4{32'd25}};
    repeat (3) tick();
    resetn = 1'b1;

    // 1: idle in INIT
    for (int i = 0; i < 50; i++) begin
      tick();
      chk("t1_idle", {busy, tg_strobe, rs_strobe, tg_reset, rpc, flip, err},
          32'd0);
    end
    chk("t1_sample", sample_index, 0);
    chk("t1_fcount", frame_count, 0);
    chk("t1_kcyc", frame_kcycles, 0);

    // 2: single pass, completion latency
    bvh = 1'b1;
    tick();
    chk("t2_setup", {tg_reset, rs_strobe, rpc, flip, busy}, 32'h1f);
    bvh = 1'b0;
    tick();
    chk("t2_rs_pulses", {tg_reset, rs_strobe, rpc, tg_strobe}, 0);
    chk("t2_rs_busy", busy, 1);
    tick();
    chk("t2_rs_wait", tg_strobe, 0);
    rs_valid = 1'b1;
    tick();
    chk("t2_render", tg_strobe, 1);
    rs_valid = 1'b0;
    for (int v = 5; v <= 25; v += 5) begin
      set_cores(32'(v));
      tick();
      chk("t2_ramp", tg_strobe, 1);
    end
    tick();
    chk("t2_drop", tg_strobe, 0);
    chk("t2_fcount", frame_count, 1);
    chk("t2_flip", flip, 1);
    chk("t2_idle", busy, 0);
    chk("t2_sample", sample_index, 0);

    // 5: vsync gating
    repeat (5) tick();
    chk("t5_hold", {busy, rs_strobe, tg_reset}, 0);
    chk("t5_fcount", frame_count, 1);
    set_cores(0);
    vsync = 1'b0;
    tick();
    chk("t5_setup", tg_reset, 1);
    chk("t5_flip", flip, 0);
    vsync = 1'b1;

    // 4: render-state timeout and retry
    for (int i = 1; i <= 15; i++) begin
      tick();
      chk("t4_wait", {busy, tg_reset, err}, 32'h4);
    end
    tick();
    chk("t4_retry", tg_reset, 1);
    chk("t4_err", err, 1);
    chk("t4_flip", flip, 0);

    // 6a: long frame for kilo-cycle count
    rs_valid = 1'b1;
    tick();
    tick();
    rs_valid = 1'b0;
    chk("t6_render", tg_strobe, 1);
    repeat (2100) tick();
    chk("t6_long", tg_strobe, 1);
    set_cores(25);
    tick();
    tick();
    chk("t6_drop", tg_strobe, 0);
    chk("t6_fcount", frame_count, 2);
    chk("t6_kcyc", frame_kcycles, exp_kc);
    chk("t6_err_sticky", err, 1);

    // 6b: reset mid-render
    set_cores(0);
    vsync = 1'b0;
    tick();
    chk("t6_flip", flip, 1);
    vsync    = 1'b1;
    rs_valid = 1'b1;
    tick();
    tick();
    rs_valid = 1'b0;
    chk("t6_render2", tg_strobe, 1);
    tick();
    resetn = 1'b0;
    tick();
    chk("t6_rst_out", {busy, tg_strobe, rs_strobe, tg_reset, rpc, flip, err},
        0);
    chk("t6_rst_cnt", {frame_count, sample_index}, 0);
    chk("t6_rst_kcyc", frame_kcycles, 0);
    resetn = 1'b1;
    tick();
    chk("t6_init", busy, 0);

    // 3: accumulation, free-run
    b_init = 1'b1;
    for (int i = 0; i < 7; i++) begin
      int cnt;
      cnt = 0;
      while (b_tg_reset !== 1'b1 && cnt < 20) begin
        tick();
        cnt++;
      end
      chk("t3_pulse_seen", b_tg_reset, 1);
      chk("t3_sample", b_sample, 32'(i % 3));
      chk("t3_flip", b_flip, ((i / 3) % 2 == 0) ? 1 : 0);
      chk("t3_fcount", b_frame_count, 32'(i / 3));
      tick();
    end

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_assert, n_fail);
    $finish;
  end

endmodule
